cpu_sequencer: RTL and testbench

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

---
 rtl/cpu_sequencer_pkg.sv | 36 +++
 rtl/cpu_sequencer_timer.sv | 39 +++
 rtl/cpu_sequencer.sv | 154 +++++++++++++++
 tb/tb_cpu_sequencer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_sequencer_pkg.sv
// Shared state encodings and opcode constants for the CPU sequencer.
// PAUSE exists only when SINGLE_STEP_EN is defined.
package cpu_sequencer_pkg;

`ifdef SINGLE_STEP_EN
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_HALT,
    ST_ERR,
    ST_PAUSE
  } state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_HALT,
    ST_ERR
  } state_e;
`endif

  localparam logic [4:0] OPC_LOAD  = 5'b00010;
  localparam logic [4:0] OPC_STORE = 5'b00011;
  localparam logic [4:0] OPC_HALT  = 5'b11111;

  function automatic logic is_mem_op(input logic [4:0] opc);
    return (opc == OPC_LOAD) || (opc == OPC_STORE);
  endfunction

endpackage

// File: rtl/cpu_sequencer_timer.sv
// mem_wait_timer: counts MEM-state wait cycles, flags when MAX is reached.
// Clear has priority over count; the counter stops at MAX.
module mem_wait_timer #(
  parameter int MAX = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count,
  output logic expired
);

  localparam int CW = (MAX < 1) ? 1 : $clog2(MAX + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign expired = (cnt_q == CW'(MAX));

  // Next count: clear, saturating increment, or hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (count && !expired) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/exec/mem/writeback sequencer with memory timeout.
// Optional single-step PAUSE state enabled by defining SINGLE_STEP_EN.
module cpu_sequencer
  import cpu_sequencer_pkg::*;
#(
  parameter int PC_W   = 8,
  parameter int OP_W   = 20,
  parameter int MEM_TO = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [OP_W-1:0] imem_data,
  input  logic            dec_reg_we,
  input  logic            dec_mem_we,
  input  logic            dec_pc_we,
  input  logic [PC_W-1:0] dec_pc_in,
  input  logic            mem_ready,
`ifdef SINGLE_STEP_EN
  input  logic            step,
`endif
  output logic [PC_W-1:0] pc,
  output logic [OP_W-1:0] ir,
  output logic            reg_we,
  output logic            mem_req,
  output logic            mem_we,
  output logic            busy,
  output logic            halted,
  output logic            err
);

  state_e          state_q;
  state_e          state_d;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;
  logic [OP_W-1:0] ir_q;
  logic [OP_W-1:0] ir_d;
  logic            tmr_clr;
  logic            tmr_cnt;
  logic            tmr_exp;
  logic [4:0]      opc;

  assign opc = ir_q[OP_W-1 -: 5];
  assign pc  = pc_q;
  assign ir  = ir_q;

  mem_wait_timer #(
    .MAX (MEM_TO)
  ) u_tmr (
    .clk     (clk),
    .rst     (rst),
    .clear   (tmr_clr),
    .count   (tmr_cnt),
    .expired (tmr_exp)
  );

  // Next state, pc/ir updates and state-decoded outputs.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    reg_we  = 1'b0;
    mem_req = 1'b0;
    mem_we  = 1'b0;
    busy    = 1'b0;
    halted  = 1'b0;
    err     = 1'b0;
    tmr_clr = 1'b1;
    tmr_cnt = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_FETCH;
          pc_d    = '0;
        end
      end
      ST_FETCH: begin
        busy    = 1'b1;
        ir_d    = imem_data;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        busy = 1'b1;
        if (opc == OPC_HALT) begin
          state_d = ST_HALT;
        end else if (is_mem_op(opc)) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        busy    = 1'b1;
        mem_req = 1'b1;
        mem_we  = dec_mem_we;
        tmr_clr = 1'b0;
        if (mem_ready) begin
          state_d = ST_WB;
          tmr_clr = 1'b1;
        end else if (tmr_exp) begin
          state_d = ST_ERR;
          tmr_clr = 1'b1;
        end else begin
          tmr_cnt = 1'b1;
        end
      end
      ST_WB: begin
        busy   = 1'b1;
        reg_we = dec_reg_we;
        pc_d   = dec_pc_we ? dec_pc_in : pc_q + 1'b1;
`ifdef SINGLE_STEP_EN
        state_d = ST_PAUSE;
`else
        state_d = ST_FETCH;
`endif
      end
      ST_HALT: begin
        halted = 1'b1;
        if (start) begin
          state_d = ST_FETCH;
          pc_d    = '0;
        end
      end
      ST_ERR: begin
        err = 1'b1;
      end
`ifdef SINGLE_STEP_EN
      ST_PAUSE: begin
        busy = 1'b1;
        if (step) begin
          state_d = ST_FETCH;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, pc and instruction registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Randomized bench for cpu_sequencer against an instruction-level model.
// Define SINGLE_STEP_EN to exercise the PAUSE variant.
module tb_cpu_sequencer;
  import cpu_sequencer_pkg::*;

  localparam int PC_W   = 8;
  localparam int OP_W   = 20;
  localparam int MEM_TO = 15;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [OP_W-1:0] imem_data;
  logic            dec_reg_we;
  logic            dec_mem_we;
  logic            dec_pc_we;
  logic [PC_W-1:0] dec_pc_in;
  logic            mem_ready;
  logic            step;
  logic [PC_W-1:0] pc;
  logic [OP_W-1:0] ir;
  logic            reg_we;
  logic            mem_req;
  logic            mem_we;
  logic            busy;
  logic            halted;
  logic            err;

  logic [OP_W-1:0] prog [256];
  logic [PC_W-1:0] pc_exp;
  int              checks = 0;
  int              errors = 0;

  assign imem_data = prog[pc];

  always #5 clk = ~clk;

  cpu_sequencer #(
    .PC_W   (PC_W),
    .OP_W   (OP_W),
    .MEM_TO (MEM_TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .imem_data  (imem_data),
    .dec_reg_we (dec_reg_we),
    .dec_mem_we (dec_mem_we),
    .dec_pc_we  (dec_pc_we),
    .dec_pc_in  (dec_pc_in),
    .mem_ready  (mem_ready),
`ifdef SINGLE_STEP_EN
    .step       (step),
`endif
    .pc         (pc),
    .ir         (ir),
    .reg_we     (reg_we),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .busy       (busy),
    .halted     (halted),
    .err        (err)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("r_pc", 32'(pc), 0);
    check("r_ir", 32'(ir), 0);
    check("r_busy", 32'(busy), 0);
    check("r_err", 32'(err), 0);
    check("r_halted", 32'(halted), 0);
    check("r_memreq", 32'(mem_req), 0);
    check("r_regwe", 32'(reg_we), 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // From IDLE or HALT: request a run; DUT ends up in FETCH at pc 0.
  task automatic go();
    check("i_busy", 32'(busy), 0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    pc_exp = '0;
  endtask

  // One instruction, entered at a negedge while in FETCH.
  // st: 0 normal completion, 1 halted, 2 memory timeout.
  task automatic do_instr(input logic [4:0] opc, input int dly,
                          input logic rwe, input logic mwe,
                          input logic pwe, input logic [7:0] pin,
                          input bit noise, output int st);
    logic [OP_W-1:0] word;
    st   = 0;
    word = {opc, 15'($urandom)};
    prog[pc_exp] = word;
    check("f_pc", 32'(pc), 32'(pc_exp));
    check("f_busy", 32'(busy), 1);
    check("f_regwe", 32'(reg_we), 0);
    check("f_memreq", 32'(mem_req), 0);
    dec_reg_we = rwe;
    dec_mem_we = mwe;
    dec_pc_we  = pwe;
    dec_pc_in  = pin;
    start = noise ? 1'($urandom) : 1'b0;
    cyc();
    check("x_ir", 32'(ir), 32'(word));
    check("x_busy", 32'(busy), 1);
    check("x_regwe", 32'(reg_we), 0);
    check("x_memreq", 32'(mem_req), 0);
    cyc();
    if (opc == OPC_HALT) begin
      start = 1'b0;
      check("h_halted", 32'(halted), 1);
      check("h_busy", 32'(busy), 0);
      check("h_pc", 32'(pc), 32'(pc_exp));
      check("h_ir", 32'(ir), 32'(word));
      st = 1;
      return;
    end
    if (opc == OPC_LOAD || opc == OPC_STORE) begin
      for (int k = 0; k <= MEM_TO; k++) begin
        check("m_req", 32'(mem_req), 1);
        check("m_we", 32'(mem_we), 32'(mwe));
        check("m_regwe", 32'(reg_we), 0);
        check("m_busy", 32'(busy), 1);
        mem_ready = (k == dly);
        if (noise) start = 1'($urandom);
        cyc();
        mem_ready = 1'b0;
        if (k == dly) break;
        if (k == MEM_TO) begin
          start = 1'b0;
          check("e_err", 32'(err), 1);
          check("e_busy", 32'(busy), 0);
          check("e_memreq", 32'(mem_req), 0);
          st = 2;
          return;
        end
      end
    end
    check("w_regwe", 32'(reg_we), 32'(rwe));
    check("w_memreq", 32'(mem_req), 0);
    check("w_memwe", 32'(mem_we), 0);
    check("w_busy", 32'(busy), 1);
    check("w_halted", 32'(halted), 0);
    cyc();
    start = 1'b0;
    pc_exp = pwe ? pin : pc_exp + 8'd1;
`ifdef SINGLE_STEP_EN
    check("p_busy", 32'(busy), 1);
    check("p_pc", 32'(pc), 32'(pc_exp));
    step = 1'b1;
    cyc();
    step = 1'b0;
`endif
  endtask

  initial begin
    int st;
    logic [4:0] opc;
    int r;
    rst = 1'b1;
    start = 1'b0;
    dec_reg_we = 1'b0;
    dec_mem_we = 1'b0;
    dec_pc_we = 1'b0;
    dec_pc_in = '0;
    mem_ready = 1'b0;
    step = 1'b0;
    pc_exp = '0;
    for (int i = 0; i < 256; i++) prog[i] = '0;
    repeat (2) @(negedge clk);
    do_reset();

    repeat (3) cyc();
    check("idle_busy", 32'(busy), 0);
    check("idle_pc", 32'(pc), 0);

    go();
    do_instr(5'b00001, 0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, st);
    check("add_pc", 32'(pc), 1);
    do_instr(5'b00100, 0, 1'b0, 1'b0, 1'b1, 8'h40, 1'b0, st);
    check("jmp_pc", 32'(pc), 32'h40);
    do_instr(OPC_STORE, 3, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, st);
    check("store_st", 32'(st), 0);
    do_instr(5'b00100, 0, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, st);
    do_instr(5'b00001, 0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, st);
    check("wrap_pc", 32'(pc), 0);
    do_instr(OPC_LOAD, MEM_TO, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, st);
    check("limit_st", 32'(st), 0);
    check("limit_err", 32'(err), 0);

    do_instr(OPC_HALT, 0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, st);
    check("halt_st", 32'(st), 1);
    repeat (3) cyc();
    check("halt_hold", 32'(halted), 1);
    check("halt_pc", 32'(pc), 32'(pc_exp));
    go();
    check("rerun_halted", 32'(halted), 0);

    for (int n = 0; n < 200; n++) begin
      r = $urandom_range(0, 99);
      if (r < 12) opc = OPC_LOAD;
      else if (r < 24) opc = OPC_STORE;
      else if (r < 27) opc = OPC_HALT;
      else begin
        opc = 5'($urandom);
        if (opc == OPC_LOAD || opc == OPC_STORE || opc == OPC_HALT)
          opc = 5'b00000;
      end
      do_instr(opc, $urandom_range(0, 6), 1'($urandom),
               1'($urandom), ($urandom_range(0, 3) == 0),
               8'($urandom), 1'b1, st);
      if (st == 1) go();
    end

    do_instr(OPC_LOAD, 1000, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, st);
    check("to_st", 32'(st), 2);
    start = 1'b1;
    repeat (3) cyc();
    start = 1'b0;
    check("to_sticky", 32'(err), 1);
    check("to_busy", 32'(busy), 0);
    check("to_pc", 32'(pc), 32'(pc_exp));
    do_reset();
    check("to_clear", 32'(err), 0);

    go();
    prog[0] = {OPC_LOAD, 15'h0};
    dec_mem_we = 1'b1;
    cyc();
    cyc();
    check("ar_req", 32'(mem_req), 1);
    check("ar_we", 32'(mem_we), 1);
    #2;
    rst = 1'b1;
    #1;
    check("ar_req0", 32'(mem_req), 0);
    check("ar_we0", 32'(mem_we), 0);
    check("ar_busy0", 32'(busy), 0);
    check("ar_pc0", 32'(pc), 0);
    @(negedge clk);
    rst = 1'b0;
    cyc();
    check("ar_idle", 32'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
